// File: rtl/seg_pkg.sv
// Shared types and helpers for the segmentation label sink: log2 ceiling,
// latency/label-width derivations, score/index pair and confidence saturation.
package seg_pkg;
  localparam int SCORE_W = 32;
  localparam int IDX_W   = 8;

  typedef struct packed {
    logic signed [SCORE_W-1:0] score;
    logic [IDX_W-1:0]          idx;
  } pair_t;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int lat_f(input int units);
    return log2c(units) + 1;
  endfunction

  function automatic int lbl_bitw_f(input int units);
    return (units > 1) ? log2c(units) : 1;
  endfunction

  // Negative -> 0, any integer bit set -> all ones, else top fractional bits.
  function automatic logic [SCORE_W-1:0] sat_conf(input logic signed [SCORE_W-1:0] s,
                                                  input int frac_bitw, input int uint_bitw);
    logic [SCORE_W-1:0] mask;
    mask = (SCORE_W'(1) << uint_bitw) - SCORE_W'(1);
    if (s < 0) return '0;
    if ((s >>> frac_bitw) != 0) return mask;
    return (SCORE_W'(s) >> (frac_bitw - uint_bitw)) & mask;
  endfunction
endpackage

// File: rtl/argmax_tree.sv
// Registered pairwise comparator tree: one register level per halving, ties
// keep the left (lower-index) operand, odd leftovers pass through.
module argmax_tree import seg_pkg::*; #(
  parameter  int UNITS = 12,
  parameter  int SW    = 13,
  localparam int LVLS  = log2c(UNITS)
) (
  input  logic                     clock,
  input  logic                     n_rst,
  input  logic                     in_valid,
  input  logic [UNITS-1:0][SW-1:0] in_scores,
  output logic                     out_valid,
  output pair_t                    out_pair
);
  pair_t       leaf  [UNITS];
  pair_t       lvl_d [LVLS][UNITS];
  pair_t       lvl_q [LVLS][UNITS];
  logic [LVLS:1] vld_pipe_d, vld_pipe_q;

  function automatic int nodes(input int l);
    return (UNITS + (1 << l) - 1) >> l;
  endfunction

  always_comb begin
    for (int u = 0; u < UNITS; u++) begin
      leaf[u].score = SCORE_W'(signed'(in_scores[u]));
      leaf[u].idx   = IDX_W'(u);
    end
  end

  always_comb begin
    pair_t a, b;
    a     = '0;
    b     = '0;
    lvl_d = '{default: '0};
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < UNITS; j++) begin
        if (j < nodes(l + 1)) begin
          if (l == 0) a = leaf[2*j];
          else        a = lvl_q[l-1][2*j];
          b = a;
          if (2*j + 1 < nodes(l)) begin
            if (l == 0) b = leaf[2*j+1];
            else        b = lvl_q[l-1][2*j+1];
          end
          lvl_d[l][j] = (b.score > a.score) ? b : a;
        end
      end
    end
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    vld_pipe_d[1] = in_valid;
    for (int i = 2; i <= LVLS; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  always_ff @(posedge clock) begin
    if (!n_rst) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
    lvl_q <= lvl_d;
  end

  assign out_valid = vld_pipe_q[LVLS];
  assign out_pair  = lvl_q[LVLS-1][0];
endmodule

// File: rtl/seg_label_sink.sv
// Per-pixel argmax label + confidence byte with aligned coordinates and
// frame-done pulse. Optional per-class histogram when SEG_HIST_EN is defined.
module seg_label_sink import seg_pkg::*; #(
  parameter  int W_HEIGHT  = 4,
  parameter  int W_WIDTH   = 8,
  parameter  int UNITS     = 12,
  parameter  int INT_BITW  = 5,
  parameter  int FRAC_BITW = 8,
  parameter  int UINT_BITW = 8,
  localparam int V_BITW    = (log2c(W_HEIGHT) > 0) ? log2c(W_HEIGHT) : 1,
  localparam int H_BITW    = (log2c(W_WIDTH) > 0) ? log2c(W_WIDTH) : 1,
  localparam int LBL_BITW  = lbl_bitw_f(UNITS),
  localparam int SW        = INT_BITW + FRAC_BITW,
  localparam int CNT_BITW  = log2c(W_HEIGHT*W_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  n_rst,
  input  logic                  in_enable,
  input  logic [0:SW*UNITS-1]   in_fmap,
  input  logic [V_BITW-1:0]     in_vcnt,
  input  logic [H_BITW-1:0]     in_hcnt,
  output logic                  out_enable,
  output logic [LBL_BITW-1:0]   out_label,
  output logic [UINT_BITW-1:0]  out_conf,
  output logic [V_BITW-1:0]     out_vcnt,
  output logic [H_BITW-1:0]     out_hcnt,
  output logic                  frame_done
`ifdef SEG_HIST_EN
  ,
  input  logic [LBL_BITW-1:0]   hist_sel,
  output logic [CNT_BITW-1:0]   hist_count
`endif
);
  localparam int TREE_LAT = lat_f(UNITS) - 1;

  logic [UNITS-1:0][SW-1:0] scores;
  logic                     tree_vld;
  pair_t                    win;

  always_comb begin
    for (int u = 0; u < UNITS; u++) scores[u] = in_fmap[u*SW +: SW];
  end

  argmax_tree #(.UNITS(UNITS), .SW(SW)) u_tree (
    .clock     (clock),
    .n_rst     (n_rst),
    .in_valid  (in_enable),
    .in_scores (scores),
    .out_valid (tree_vld),
    .out_pair  (win)
  );

  // Coordinates ride alongside the tree levels so they emerge with the winner.
  logic [TREE_LAT-1:0][V_BITW-1:0] vc_d, vc_q;
  logic [TREE_LAT-1:0][H_BITW-1:0] hc_d, hc_q;

  always_comb begin
    vc_d = vc_q;
    hc_d = hc_q;
    vc_d[0] = in_vcnt;
    hc_d[0] = in_hcnt;
    for (int i = 1; i < TREE_LAT; i++) begin
      vc_d[i] = vc_q[i-1];
      hc_d[i] = hc_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    vc_q <= vc_d;
    hc_q <= hc_d;
  end

  logic [V_BITW-1:0]    pix_v;
  logic [H_BITW-1:0]    pix_h;
  logic [LBL_BITW-1:0]  pix_lbl;
  logic                 pix_last;
  assign pix_v    = vc_q[TREE_LAT-1];
  assign pix_h    = hc_q[TREE_LAT-1];
  assign pix_lbl  = LBL_BITW'(win.idx);
  assign pix_last = tree_vld && (pix_v == V_BITW'(W_HEIGHT-1)) && (pix_h == H_BITW'(W_WIDTH-1));

  logic                 out_enable_d, out_enable_q, frame_done_d, frame_done_q;
  logic [LBL_BITW-1:0]  out_label_d, out_label_q;
  logic [UINT_BITW-1:0] out_conf_d, out_conf_q;
  logic [V_BITW-1:0]    out_vcnt_d, out_vcnt_q;
  logic [H_BITW-1:0]    out_hcnt_d, out_hcnt_q;

  always_comb begin
    out_enable_d = tree_vld;
    frame_done_d = pix_last;
    out_label_d  = out_label_q;
    out_conf_d   = out_conf_q;
    out_vcnt_d   = out_vcnt_q;
    out_hcnt_d   = out_hcnt_q;
    if (tree_vld) begin
      out_label_d = pix_lbl;
      out_conf_d  = UINT_BITW'(sat_conf(win.score, FRAC_BITW, UINT_BITW));
      out_vcnt_d  = pix_v;
      out_hcnt_d  = pix_h;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      out_enable_q <= 1'b0;
      frame_done_q <= 1'b0;
      out_label_q  <= '0;
      out_conf_q   <= '0;
      out_vcnt_q   <= '0;
      out_hcnt_q   <= '0;
    end else begin
      out_enable_q <= out_enable_d;
      frame_done_q <= frame_done_d;
      out_label_q  <= out_label_d;
      out_conf_q   <= out_conf_d;
      out_vcnt_q   <= out_vcnt_d;
      out_hcnt_q   <= out_hcnt_d;
    end
  end

  assign out_enable = out_enable_q;
  assign frame_done = frame_done_q;
  assign out_label  = out_label_q;
  assign out_conf   = out_conf_q;
  assign out_vcnt   = out_vcnt_q;
  assign out_hcnt   = out_hcnt_q;

`ifdef SEG_HIST_EN
  logic [CNT_BITW-1:0] cnt_d [UNITS], cnt_q [UNITS], snap_d [UNITS], snap_q [UNITS];
  logic [CNT_BITW-1:0] hist_count_d, hist_count_q;

  // Pixel (0,0) restarts the live counts; the frame's last pixel is folded
  // into the snapshot in the same cycle it is counted.
  always_comb begin
    cnt_d = cnt_q;
    if (tree_vld) begin
      for (int u = 0; u < UNITS; u++) begin
        if (pix_v == '0 && pix_h == '0)
          cnt_d[u] = (LBL_BITW'(u) == pix_lbl) ? CNT_BITW'(1) : '0;
        else if (LBL_BITW'(u) == pix_lbl && cnt_q[u] != '1)
          cnt_d[u] = cnt_q[u] + CNT_BITW'(1);
      end
    end
    snap_d = pix_last ? cnt_d : snap_q;
    hist_count_d = '0;
    if (int'(hist_sel) < UNITS) hist_count_d = snap_q[hist_sel];
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      cnt_q        <= '{default: '0};
      snap_q       <= '{default: '0};
      hist_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      hist_count_q <= hist_count_d;
    end
  end

  assign hist_count = hist_count_q;
`endif
endmodule

// File: tb/tb_seg_label_sink.sv
// Scoreboard bench for seg_label_sink: expectations queued at drive time,
// checked (including arrival cycle) whenever out_enable is seen.
module tb_seg_label_sink;
  localparam int UNITS = 12;
  localparam int SW    = 13;
  localparam int WH    = 4;
  localparam int WW    = 8;
  localparam int LAT   = 5;

  logic               clock = 1'b0;
  logic               n_rst, in_enable;
  logic [0:SW*UNITS-1] in_fmap;
  logic [1:0]         in_vcnt;
  logic [2:0]         in_hcnt;
  logic               out_enable, frame_done;
  logic [3:0]         out_label;
  logic [7:0]         out_conf;
  logic [1:0]         out_vcnt;
  logic [2:0]         out_hcnt;
`ifdef SEG_HIST_EN
  logic [3:0]         hist_sel;
  logic [5:0]         hist_count;
`endif

  typedef struct { int lbl; int conf; int v; int h; int fd; int cyc; } exp_t;
  exp_t sbq[$];
  int   n_cmp = 0, n_err = 0, cyc = 0, fd_cnt = 0;
  int   sc [UNITS];

  seg_label_sink #(.W_HEIGHT(WH), .W_WIDTH(WW), .UNITS(UNITS),
                   .INT_BITW(5), .FRAC_BITW(8), .UINT_BITW(8)) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .in_enable  (in_enable),
    .in_fmap    (in_fmap),
    .in_vcnt    (in_vcnt),
    .in_hcnt    (in_hcnt),
    .out_enable (out_enable),
    .out_label  (out_label),
    .out_conf   (out_conf),
    .out_vcnt   (out_vcnt),
    .out_hcnt   (out_hcnt),
    .frame_done (frame_done)
`ifdef SEG_HIST_EN
    ,
    .hist_sel   (hist_sel),
    .hist_count (hist_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_lbl();
    int best = 0;
    for (int u = 1; u < UNITS; u++) if (sc[u] > sc[best]) best = u;
    return best;
  endfunction

  function automatic int ref_conf(input int s);
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  always @(negedge clock) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (out_enable === 1'b1) begin
      if (sbq.size() == 0) check("spurious_out", 32'(out_enable), 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("label", 32'(out_label), e.lbl);
        check("conf",  32'(out_conf),  e.conf);
        check("vcnt",  32'(out_vcnt),  e.v);
        check("hcnt",  32'(out_hcnt),  e.h);
        check("fdone", 32'(frame_done), e.fd);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int v, input int h);
    exp_t e;
    for (int u = 0; u < UNITS; u++) in_fmap[u*SW +: SW] = SW'(sc[u]);
    in_vcnt   = 2'(v);
    in_hcnt   = 3'(h);
    in_enable = 1'b1;
    e.lbl  = ref_lbl();
    e.conf = ref_conf(sc[e.lbl]);
    e.v    = v;
    e.h    = h;
    e.fd   = (v == WH-1 && h == WW-1) ? 1 : 0;
    e.cyc  = cyc + LAT;
    sbq.push_back(e);
    idle(1);
    in_enable = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1);
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic fill(input int val);
    for (int u = 0; u < UNITS; u++) sc[u] = val;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_en"},    32'(out_enable), 0);
    check({pfx, "_label"}, 32'(out_label),  0);
    check({pfx, "_conf"},  32'(out_conf),   0);
    check({pfx, "_vcnt"},  32'(out_vcnt),   0);
    check({pfx, "_hcnt"},  32'(out_hcnt),   0);
    check({pfx, "_fdone"}, 32'(frame_done), 0);
`ifdef SEG_HIST_EN
    check({pfx, "_hist"},  32'(hist_count), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; in_enable = 1'b0; in_fmap = '0; in_vcnt = '0; in_hcnt = '0;
`ifdef SEG_HIST_EN
    hist_sel = '0;
`endif
    idle(2);
    check_zero_outputs("rst");
    n_rst = 1'b1;
    idle(1);

    // 0.75 on unit 5
    fill(0); sc[5] = 'h0C0; send(2, 5); drain();
    // tie at 1.0 on units 3 and 7
    fill(-5); sc[3] = 'h100; sc[7] = 'h100; send(1, 6); drain();
    // all negative, max -1/256 on unit 11
    for (int u = 0; u < 11; u++) sc[u] = -100 + u;
    sc[11] = -1; send(0, 3); drain();
    // all equal, max positive, just-below-one, smallest fraction
    fill('h050); send(3, 0);
    fill(-4096); sc[9] = 'h0FFF; send(3, 1);
    fill(-4096); sc[6] = 'h0FF; send(3, 2);
    fill(-1); sc[2] = 'h001; send(3, 3);
    drain();
    // gaps propagate as gaps
    fill(0); sc[1] = 'h040; send(0, 0); idle(2);
    sc[10] = 'h050; send(0, 1); drain();

    // full window back-to-back with random scores
    fd_cnt = 0;
    for (int v = 0; v < WH; v++)
      for (int h = 0; h < WW; h++) begin
        for (int u = 0; u < UNITS; u++) sc[u] = int'($urandom_range(0, 600)) - 300;
        send(v, h);
      end
    drain();
    check("fd_pulses", fd_cnt, 1);

    // reset with three pixels in flight
    fill(0); sc[4] = 'h030; send(1, 1);
    sc[8] = 'h090; send(1, 2);
    sc[9] = 'h0A0; send(1, 3);
    n_rst = 1'b0;
    sbq.delete();
    idle(1);
    check_zero_outputs("midrst");
    n_rst = 1'b1;
    idle(8);
    fill(0); sc[7] = 'h011; send(2, 2); drain();

`ifdef SEG_HIST_EN
    fill(0); sc[2] = 'h080;
    for (int v = 0; v < WH; v++)
      for (int h = 0; h < WW; h++) send(v, h);
    drain();
    hist_sel = 4'd2; idle(1);
    check("hist2_f1", 32'(hist_count), 32);
    for (int v = 0; v < WH; v++)
      for (int h = 0; h < WW; h++) begin
        fill(0);
        if (v < 2) sc[0] = 'h080; else sc[2] = 'h080;
        send(v, h);
      end
    drain();
    hist_sel = 4'd2; idle(1);
    check("hist2_f2", 32'(hist_count), 16);
    hist_sel = 4'd0; idle(1);
    check("hist0_f2", 32'(hist_count), 16);
    hist_sel = 4'd13; idle(1);
    check("hist_oob", 32'(hist_count), 0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
